// File: rtl/des_pkg.sv
// des_pkg: shared definitions for the deserializer frame-alignment controller.
//   des_align_state_t : alignment FSM states
//   DES_NPHASE        : number of candidate phi_init phases
//   DES_W             : default sample width
package des_pkg;

  localparam int DES_NPHASE = 4;
  localparam int DES_W      = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } des_align_state_t;

endpackage

// File: rtl/des_align_ctrl.sv
// des_align_ctrl: frame-alignment controller for the 72:288 deserializer.
// Steps the deserializer through each phi_init phase, resetting it and
// comparing lane-0 frames against the training pattern, and locks on the
// first phase that yields CHECK_FRAMES consecutive matches.
//
// Ports:
//   clk        fast deserializer clock (only clock)
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse, begin/restart alignment
//   train_en   ADC is sending the training pattern
//   train_pat  expected frame {s3,s2,s1,s0}
//   frame      lane-0 deserializer frame {out_24,out_16,out_8,out_0}
//   frame_vld  one-cycle pulse, frame is new
//   des_rst    active-high reset to the deserializer
//   phi_init   phase preset to the deserializer (current candidate)
//   locked     alignment found
//   fail       all phases failed (sticky until next start)
//   busy       alignment in progress
//
// Build option: define DES_ALIGN_MONITOR_EN to keep watching frames while
// locked and realign after ERR_LIMIT consecutive mismatches.
//
// state  | meaning
// IDLE   | waiting for start, deserializer held in reset
// RST    | 2-cycle deserializer reset at the current candidate phase
// SETTLE | deserializer running, frames ignored for SETTLE_CYC cycles
// CHECK  | counting consecutive matching training frames
// LOCKED | alignment found, candidate phase held
// FAIL   | no phase matched, deserializer left running at phase 3
module des_align_ctrl
  import des_pkg::*;
#(
  parameter int W            = DES_W,
  parameter int SETTLE_CYC   = 16,
  parameter int CHECK_FRAMES = 8,
  parameter int ERR_LIMIT    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           train_en,
  input  logic [4*W-1:0] train_pat,
  input  logic [4*W-1:0] frame,
  input  logic           frame_vld,
  output logic           des_rst,
  output logic [1:0]     phi_init,
  output logic           locked,
  output logic           fail,
  output logic           busy
);

  localparam int TW = $clog2(SETTLE_CYC + 1);
  localparam int MW = $clog2(CHECK_FRAMES + 1);
  localparam logic [1:0] LAST_CAND = 2'(DES_NPHASE - 1);

  if (SETTLE_CYC < 1 || CHECK_FRAMES < 1 || ERR_LIMIT < 1) begin : g_param_chk
    $error("des_align_ctrl: SETTLE_CYC, CHECK_FRAMES and ERR_LIMIT must be >= 1");
  end

  des_align_state_t state, state_nx;
  logic [1:0]    cand, cand_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic [MW-1:0] mcnt, mcnt_nx;
`ifdef DES_ALIGN_MONITOR_EN
  localparam int EW = $clog2(ERR_LIMIT + 1);
  logic [EW-1:0] ecnt, ecnt_nx;
`endif

  logic frame_ok, frame_evt;

  assign frame_ok  = (frame == train_pat);
  assign frame_evt = frame_vld & train_en;
  assign phi_init  = cand;

  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    tmr_nx   = tmr;
    mcnt_nx  = mcnt;
`ifdef DES_ALIGN_MONITOR_EN
    ecnt_nx  = ecnt;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_RST;
          cand_nx  = 2'd0;
          tmr_nx   = '0;
        end
      end
      // tmr doubles as the 2-cycle reset-pulse counter
      ST_RST: begin
        if (tmr == TW'(1)) begin
          state_nx = ST_SETTLE;
          tmr_nx   = '0;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      ST_SETTLE: begin
        if (tmr == TW'(SETTLE_CYC - 1)) begin
          state_nx = ST_CHECK;
          mcnt_nx  = '0;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      ST_CHECK: begin
        if (frame_evt) begin
          if (frame_ok) begin
            mcnt_nx = mcnt + MW'(1);
            if (mcnt == MW'(CHECK_FRAMES - 1)) begin
              state_nx = ST_LOCKED;
`ifdef DES_ALIGN_MONITOR_EN
              ecnt_nx  = '0;
`endif
            end
          end else if (cand == LAST_CAND) begin
            state_nx = ST_FAIL;
          end else begin
            state_nx = ST_RST;
            cand_nx  = cand + 2'd1;
            tmr_nx   = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (start) begin
          state_nx = ST_RST;
          cand_nx  = 2'd0;
          tmr_nx   = '0;
        end
`ifdef DES_ALIGN_MONITOR_EN
        else if (frame_evt) begin
          if (frame_ok) begin
            ecnt_nx = '0;
          end else if (ecnt == EW'(ERR_LIMIT - 1)) begin
            state_nx = ST_RST;
            cand_nx  = 2'd0;
            tmr_nx   = '0;
            ecnt_nx  = '0;
          end else begin
            ecnt_nx = ecnt + EW'(1);
          end
        end
`endif
      end
      ST_FAIL: begin
        if (start) begin
          state_nx = ST_RST;
          cand_nx  = 2'd0;
          tmr_nx   = '0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Flags are registered from the next state so they line up with the
  // state register rather than lagging it by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cand    <= 2'd0;
      tmr     <= '0;
      mcnt    <= '0;
`ifdef DES_ALIGN_MONITOR_EN
      ecnt    <= '0;
`endif
      des_rst <= 1'b1;
      locked  <= 1'b0;
      fail    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      cand    <= cand_nx;
      tmr     <= tmr_nx;
      mcnt    <= mcnt_nx;
`ifdef DES_ALIGN_MONITOR_EN
      ecnt    <= ecnt_nx;
`endif
      des_rst <= (state_nx == ST_IDLE) || (state_nx == ST_RST);
      locked  <= (state_nx == ST_LOCKED);
      fail    <= (state_nx == ST_FAIL);
      busy    <= (state_nx == ST_RST) || (state_nx == ST_SETTLE) ||
                 (state_nx == ST_CHECK);
    end
  end

endmodule

// File: doc/des_align_ctrl.md
# des_align_ctrl

Frame-alignment controller for the 72:288 deserializer. At start-up the ADC sends a known training frame. This block resets the deserializer at each candidate `phi_init` phase (0 to 3) in turn and checks lane-0 output frames against the expected training pattern. It locks on the first phase that gives `CHECK_FRAMES` consecutive matching frames. It sits beside the deserializer in the fast `clk` domain and drives that block's `rst` and `phi_init` inputs.

## Interface
Parameters:
- `W`, 9: sample width.
- `SETTLE_CYC`, 16: `clk` cycles to wait after deserializer reset release before checking starts.
- `CHECK_FRAMES`, 8: consecutive matching frames required to lock.
- `ERR_LIMIT`, 4: consecutive mismatches that drop lock (monitor only).

Ports (clock and reset first):
- `clk`  in  1: fast deserializer clock. This is the only clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: one-cycle pulse that begins (or restarts) alignment.
- `train_en`  in  1: high while the ADC is sending the training pattern.
- `train_pat`  in  4*W: expected frame, packed `{s3,s2,s1,s0}`.
- `frame`  in  4*W: lane-0 deserializer outputs packed `{out_24,out_16,out_8,out_0}`.
- `frame_vld`  in  1: one-cycle pulse, asserted the cycle after the deserializer outputs update.
- `des_rst`  out  1: active-high reset to the deserializer.
- `phi_init`  out  2: phase preset to the deserializer.
- `locked`  out  1: alignment found.
- `fail`  out  1: all 4 phases failed. Sticky until the next `start`.
- `busy`  out  1: alignment in progress (states RST, SETTLE, CHECK).

## Operation
States: IDLE, RST, SETTLE, CHECK, LOCKED, FAIL.

Registers:
- `cand`: 2-bit candidate phase.
- `tmr`: settle counter, `$clog2(SETTLE_CYC+1)` bits.
- `mcnt`: match counter, `$clog2(CHECK_FRAMES+1)` bits.
- `ecnt`: error counter, `$clog2(ERR_LIMIT+1)` bits.

Output relations:
- `phi_init` = `cand` at all times.
- `locked` is 1 only in LOCKED; `fail` is 1 only in FAIL.

State behaviour:
- **IDLE**: `des_rst`=1. On `start`: `cand`←0, go to RST.
- **RST**: `des_rst`=1 for exactly 2 cycles, then go to SETTLE with `tmr`←0.
- **SETTLE**: `des_rst`=0. `tmr` increments each cycle; when `tmr`==`SETTLE_CYC`-1, go to CHECK with `mcnt`←0. `frame_vld` is ignored in SETTLE.
- **CHECK**: acts only on `frame_vld` while `train_en`=1.
  - Match (`frame`==`train_pat`): `mcnt`++. If `mcnt` reaches `CHECK_FRAMES`, go to LOCKED with `ecnt`←0.
  - Mismatch: if `cand`==3, go to FAIL; otherwise `cand`++ and go to RST.
  - `frame_vld` while `train_en`=0: no effect; the state holds.
- **LOCKED**: `des_rst`=0, `cand` held. `start` causes realignment (`cand`←0, go to RST).
- **FAIL**: `des_rst`=0, deserializer left running at `cand`=3. `start` goes to RST with `cand`←0.
- `start` in RST, SETTLE or CHECK is ignored.
- `start` and `frame_vld` in the same cycle in LOCKED: `start` wins.

Reset (`rst_n`=0, any time, including mid-CHECK):
- State←IDLE.
- `des_rst`=1, `phi_init`=0, `locked`=0, `fail`=0, `busy`=0.
- All counters cleared.

## Timing
- All outputs are registered and change the cycle after the triggering edge.
- One attempt takes 2 (RST) + `SETTLE_CYC` + checking cycles.
- Lock latency after the final matching `frame_vld`: 1 cycle to `locked`=1.
- Mismatch in CHECK: `des_rst` rises the next cycle with the new `phi_init`.
- `phi_init` changes only on the entry cycle to RST, so it is stable during the whole `des_rst` pulse.

## Configuration
Macro: `DES_ALIGN_MONITOR_EN`.

With the macro defined, in LOCKED:
- On each `frame_vld` with `train_en`=1: mismatch → `ecnt`++; match → `ecnt`←0.
- When `ecnt` reaches `ERR_LIMIT`: `locked`←0, `cand`←0, go to RST.

Without the macro, LOCKED ignores `frame` and `frame_vld`; `ecnt` and its logic are absent.

## Structure
- Shared package `des_pkg`:
  - state enum `des_align_state_t`;
  - constant `DES_NPHASE`=4;
  - localparam `DES_W`=9.
- No sub-module is needed. Frame comparison is a single equality against the packed pattern, kept inline.

## Test plan
Use `SETTLE_CYC`=16 and `CHECK_FRAMES`=8 throughout.
1. Model the deserializer so frames match only when `phi_init`=2. Pulse `start` → `des_rst` pulses at `phi_init`=0, 1, 2; `locked`=1 after the 8th match; `phi_init`=2 holds; `busy`=0.
2. Frames never match → four attempts, then `fail`=1 with `phi_init`=3. The next `start` clears `fail` and `des_rst` rises with `phi_init`=0.
3. At phase 0, 7 matches then a mismatch → `cand`=1 and RST the next cycle; `mcnt` restarts from 0.
4. `rst_n` pulled low mid-CHECK at phase 1 → all outputs immediately at reset values (`des_rst`=1, `phi_init`=0, flags 0). After release, stays IDLE until `start`.
5. With `DES_ALIGN_MONITOR_EN`, in LOCKED: 3 mismatches then 1 match → stays locked. Then 4 consecutive mismatches → `locked`=0 and `des_rst`=1 the next cycle, `phi_init`=0. Without the macro, the same stimulus keeps `locked`=1.
6. `train_en`=0 during CHECK with `frame_vld` pulses → no state change and `mcnt` unchanged.
